// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch (register-read) stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package operand_fetch_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int REG_IDX_W = 5;

    // Architectural zero register; reads as 0 and never forwards.
    localparam logic [REG_IDX_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        FULL = 2'd3
    } state_e;

endpackage

// File: rtl/operand_fetch_slot.sv
// One operand slot: issue-cycle forward capture, capture priority mux, hold register, post-capture snoop.
// Latency: value registered on the capture edge; snoop updates land on the edge of the wb write.
// Backpressure: none; the parent FSM decides when to issue, capture and hold.
//
// Ports: clk_i/reset_i (sync, active-high); issue_i + issue_idx_i mark the cycle the RAM
// address is sampled; capture_i loads the operand using idx_i; held_i enables the snoop;
// rdata_i is the RAM read data; wb_* is the writeback bus; val_o is the held operand.
module operand_fetch_slot
    import operand_fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 issue_i,
    input  logic [REG_IDX_W-1:0] issue_idx_i,
    input  logic                 capture_i,
    input  logic                 held_i,
    input  logic [REG_IDX_W-1:0] idx_i,
    input  logic [XLEN-1:0]      rdata_i,
    input  logic                 wb_wen_i,
    input  logic [REG_IDX_W-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]      wb_wdata_i,
    output logic [XLEN-1:0]      val_o
);

    logic            fwd_vld_q, fwd_vld_d;
    logic [XLEN-1:0] fwd_dat_q, fwd_dat_d;
    logic [XLEN-1:0] val_q, val_d;
    logic [XLEN-1:0] cap_val;
    logic            wb_hit;

    always_comb begin
        // A write landing in the same cycle the RAM samples the address makes
        // the RAM's read data unreliable, so remember the written value.
        fwd_vld_d = fwd_vld_q;
        fwd_dat_d = fwd_dat_q;
        if (issue_i) begin
            fwd_vld_d = wb_wen_i && (wb_waddr_i == issue_idx_i) && (issue_idx_i != X0);
            fwd_dat_d = wb_wdata_i;
        end

        wb_hit = wb_wen_i && (wb_waddr_i == idx_i) && (idx_i != X0);

        // Assigned lowest priority first so later assignments win.
        cap_val = rdata_i;
        if (fwd_vld_q) begin
            cap_val = fwd_dat_q;
        end
        if (wb_hit) begin
            cap_val = wb_wdata_i;
        end
        if (idx_i == X0) begin
            cap_val = '0;
        end

        val_d = val_q;
        if (capture_i) begin
            val_d = cap_val;
        end else if (held_i && wb_hit) begin
            val_d = wb_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd_vld_q <= 1'b0;
            fwd_dat_q <= '0;
            val_q     <= '0;
        end else begin
            fwd_vld_q <= fwd_vld_d;
            fwd_dat_q <= fwd_dat_d;
            val_q     <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: sequences rs1/rs2 reads through one synchronous RAM port, forwards wb data, zeroes x0.
// Latency: accept to ex_valid_o is 2 cycles (rs1 only) or 3 cycles (rs1+rs2).
// Backpressure: holds operands in FULL while ex_ready_i=0; accepts only in IDLE or on the FULL handoff cycle.
//
// Ports: dec_* decode-side valid/ready + rs1/rs2/need_rs2/payload; rf_raddr_o/rf_rdata_i RAM
// read port (data one cycle after address); wb_* writeback bus; ex_* execute-side valid/ready
// with both operands and the payload.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic [REG_IDX_W-1:0] dec_rs1_i,
    input  logic [REG_IDX_W-1:0] dec_rs2_i,
    input  logic                 dec_need_rs2_i,
    input  logic [PAYLOAD_W-1:0] dec_payload_i,
    output logic [REG_IDX_W-1:0] rf_raddr_o,
    input  logic [XLEN-1:0]      rf_rdata_i,
    input  logic                 wb_wen_i,
    input  logic [REG_IDX_W-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]      wb_wdata_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [XLEN-1:0]      ex_rs1_val_o,
    output logic [XLEN-1:0]      ex_rs2_val_o,
    output logic [PAYLOAD_W-1:0] ex_payload_o
);

    state_e               state_q, state_d;
    logic [REG_IDX_W-1:0] rs1_q, rs1_d;
    logic [REG_IDX_W-1:0] rs2_q, rs2_d;
    logic                 need_rs2_q, need_rs2_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 accept;
    logic [REG_IDX_W-1:0] rs2_idx;

    assign dec_ready_o = (state_q == IDLE) || ((state_q == FULL) && ex_ready_i);
    assign accept      = dec_valid_i && dec_ready_o;

    // When rs2 is unused the slot is pointed at x0, so the RD1 capture
    // yields zero and the snoop can never disturb it.
    assign rs2_idx = need_rs2_q ? rs2_q : X0;

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        need_rs2_d = need_rs2_q;
        payload_d  = payload_q;
        rf_raddr_o = '0;
        ex_valid_o = 1'b0;

        if (accept) begin
            rs1_d      = dec_rs1_i;
            rs2_d      = dec_rs2_i;
            need_rs2_d = dec_need_rs2_i;
            payload_d  = dec_payload_i;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rf_raddr_o = dec_rs1_i;
                    state_d    = RD1;
                end
            end
            RD1: begin
                rf_raddr_o = rs2_q;
                state_d    = need_rs2_q ? RD2 : FULL;
            end
            RD2: begin
                rf_raddr_o = rs2_q;
                state_d    = FULL;
            end
            FULL: begin
                ex_valid_o = 1'b1;
                if (accept) begin
                    rf_raddr_o = dec_rs1_i;
                    state_d    = RD1;
                end else if (ex_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            need_rs2_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            need_rs2_q <= need_rs2_d;
            payload_q  <= payload_d;
        end
    end

    operand_fetch_slot #(.XLEN(XLEN)) u_slot_rs1 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .issue_i     (accept),
        .issue_idx_i (dec_rs1_i),
        .capture_i   (state_q == RD1),
        .held_i      ((state_q == RD2) || (state_q == FULL)),
        .idx_i       (rs1_q),
        .rdata_i     (rf_rdata_i),
        .wb_wen_i    (wb_wen_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .val_o       (ex_rs1_val_o)
    );

    operand_fetch_slot #(.XLEN(XLEN)) u_slot_rs2 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .issue_i     ((state_q == RD1) && need_rs2_q),
        .issue_idx_i (rs2_q),
        .capture_i   (((state_q == RD1) && !need_rs2_q) || (state_q == RD2)),
        .held_i      (state_q == FULL),
        .idx_i       (rs2_idx),
        .rdata_i     (rf_rdata_i),
        .wb_wen_i    (wb_wen_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .val_o       (ex_rs2_val_o)
    );

    assign ex_payload_o = payload_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: bench-side RAM, architectural register-file model, directed + random stimulus.
// Latency: n/a.
// Backpressure: ex_ready_i driven both directed and randomly.
module tb_operand_fetch;

    localparam int XLEN = 64;
    localparam int PW   = 32;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            dec_valid_i = 1'b0;
    logic            dec_ready_o;
    logic [4:0]      dec_rs1_i = '0;
    logic [4:0]      dec_rs2_i = '0;
    logic            dec_need_rs2_i = 1'b0;
    logic [PW-1:0]   dec_payload_i = '0;
    logic [4:0]      rf_raddr_o;
    logic [XLEN-1:0] rf_rdata_i = '0;
    logic            wb_wen_i = 1'b0;
    logic [4:0]      wb_waddr_i = '0;
    logic [XLEN-1:0] wb_wdata_i = '0;
    logic            ex_valid_o;
    logic            ex_ready_i = 1'b0;
    logic [XLEN-1:0] ex_rs1_val_o;
    logic [XLEN-1:0] ex_rs2_val_o;
    logic [PW-1:0]   ex_payload_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .dec_valid_i    (dec_valid_i),
        .dec_ready_o    (dec_ready_o),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_need_rs2_i (dec_need_rs2_i),
        .dec_payload_i  (dec_payload_i),
        .rf_raddr_o     (rf_raddr_o),
        .rf_rdata_i     (rf_rdata_i),
        .wb_wen_i       (wb_wen_i),
        .wb_waddr_i     (wb_waddr_i),
        .wb_wdata_i     (wb_wdata_i),
        .ex_valid_o     (ex_valid_o),
        .ex_ready_i     (ex_ready_i),
        .ex_rs1_val_o   (ex_rs1_val_o),
        .ex_rs2_val_o   (ex_rs2_val_o),
        .ex_payload_o   (ex_payload_o)
    );

    // Register-file RAM: synchronous read; read-during-write to the same
    // address returns junk so any reliance on it shows up as a wrong value.
    logic [XLEN-1:0] mem [32];
    always @(posedge clk) begin
        if (wb_wen_i && (wb_waddr_i == rf_raddr_o)) rf_rdata_i <= {$urandom, $urandom};
        else                                         rf_rdata_i <= mem[rf_raddr_o];
        if (wb_wen_i) mem[wb_waddr_i] <= wb_wdata_i;
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: the execute stage must always see the current
    // architectural register contents (x0 reads 0), after 2 or 3 cycles.
    logic [XLEN-1:0] arch [32];
    bit              m_pend = 1'b0;
    int              m_cnt  = 0;
    logic [4:0]      m_rs1, m_rs2;
    bit              m_need;
    logic [PW-1:0]   m_pay;

    function automatic logic [XLEN-1:0] regval(input logic [4:0] idx);
        return (idx == 5'd0) ? '0 : arch[idx];
    endfunction

    always @(negedge clk) begin
        bit exp_valid, exp_ready, acc;
        exp_valid = m_pend && (m_cnt == 0);
        exp_ready = !m_pend || (exp_valid && ex_ready_i);
        acc       = dec_valid_i && exp_ready;
        if (chk_en) begin
            check("dec_ready", {63'd0, dec_ready_o}, {63'd0, exp_ready});
            check("ex_valid", {63'd0, ex_valid_o}, {63'd0, exp_valid});
            if (exp_valid) begin
                check("ex_rs1_val", ex_rs1_val_o, regval(m_rs1));
                check("ex_rs2_val", ex_rs2_val_o, m_need ? regval(m_rs2) : '0);
                check("ex_payload", {32'd0, ex_payload_o}, {32'd0, m_pay});
            end
            if (acc)                               check("raddr_rs1", {59'd0, rf_raddr_o}, {59'd0, dec_rs1_i});
            else if (m_pend && m_need && m_cnt == 2) check("raddr_rs2", {59'd0, rf_raddr_o}, {59'd0, m_rs2});
            else if (!m_pend && !dec_valid_i)        check("raddr_idle", {59'd0, rf_raddr_o}, 64'd0);
        end
        if (reset_i) begin
            m_pend = 1'b0;
        end else begin
            if (exp_valid && ex_ready_i) m_pend = 1'b0;
            else if (m_pend && m_cnt > 0) m_cnt--;
            if (acc) begin
                m_pend = 1'b1;
                m_cnt  = dec_need_rs2_i ? 2 : 1;
                m_rs1  = dec_rs1_i;
                m_rs2  = dec_rs2_i;
                m_need = dec_need_rs2_i;
                m_pay  = dec_payload_i;
            end
        end
        if (wb_wen_i) arch[wb_waddr_i] = wb_wdata_i;
    end

    initial begin
        // Preload the register file through the writeback port while in reset.
        for (int i = 0; i < 32; i++) begin
            wb_wen_i   = 1'b1;
            wb_waddr_i = 5'(i);
            case (i)
                0:       wb_wdata_i = 64'h77;
                2:       wb_wdata_i = 64'h42;
                5:       wb_wdata_i = 64'h1111;
                6:       wb_wdata_i = 64'h2222;
                7:       wb_wdata_i = 64'h0;
                9:       wb_wdata_i = 64'h1234;
                default: wb_wdata_i = {$urandom, $urandom};
            endcase
            step();
            chk_en = 1'b1;
        end
        wb_wen_i = 1'b0;
        step();
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_ex_valid", {63'd0, ex_valid_o}, 64'd0);
        check("rst_dec_ready", {63'd0, dec_ready_o}, 64'd1);
        check("rst_rs1", ex_rs1_val_o, 64'd0);
        check("rst_rs2", ex_rs2_val_o, 64'd0);
        check("rst_payload", {32'd0, ex_payload_o}, 64'd0);

        // Two-read instruction.
        step();
        dec_valid_i = 1'b1; dec_rs1_i = 5'd5; dec_rs2_i = 5'd6; dec_need_rs2_i = 1'b1;
        dec_payload_i = 32'hABCD; ex_ready_i = 1'b0;
        @(negedge clk); check("t2_raddr_a", {59'd0, rf_raddr_o}, 64'd5);
        step(); dec_valid_i = 1'b0;
        @(negedge clk); check("t2_raddr_b", {59'd0, rf_raddr_o}, 64'd6);
        step();
        step(); ex_ready_i = 1'b1;
        @(negedge clk);
        check("t2_valid", {63'd0, ex_valid_o}, 64'd1);
        check("t2_rs1", ex_rs1_val_o, 64'h1111);
        check("t2_rs2", ex_rs2_val_o, 64'h2222);
        check("t2_payload", {32'd0, ex_payload_o}, 64'hABCD);
        step(); ex_ready_i = 1'b0;

        // x0 reads zero despite writes to it in the capture cycles.
        dec_valid_i = 1'b1; dec_rs1_i = 5'd0; dec_rs2_i = 5'd0; dec_need_rs2_i = 1'b1;
        step(); dec_valid_i = 1'b0; wb_wen_i = 1'b1; wb_waddr_i = 5'd0; wb_wdata_i = 64'hFFFF;
        step();
        step(); wb_wen_i = 1'b0; ex_ready_i = 1'b1;
        @(negedge clk);
        check("t3_rs1", ex_rs1_val_o, 64'd0);
        check("t3_rs2", ex_rs2_val_o, 64'd0);
        step(); ex_ready_i = 1'b0;

        // Write in the issue cycle.
        dec_valid_i = 1'b1; dec_rs1_i = 5'd7; dec_need_rs2_i = 1'b0;
        wb_wen_i = 1'b1; wb_waddr_i = 5'd7; wb_wdata_i = 64'hDEAD;
        step(); dec_valid_i = 1'b0; wb_wen_i = 1'b0;
        step(); ex_ready_i = 1'b1;
        @(negedge clk);
        check("t4a_rs1", ex_rs1_val_o, 64'hDEAD);
        check("t4a_rs2", ex_rs2_val_o, 64'd0);
        step(); ex_ready_i = 1'b0;
        wb_wen_i = 1'b1; wb_waddr_i = 5'd7; wb_wdata_i = 64'h0;
        step(); wb_wen_i = 1'b0;

        // Write in the capture cycle.
        dec_valid_i = 1'b1; dec_rs1_i = 5'd7; dec_need_rs2_i = 1'b0;
        step(); dec_valid_i = 1'b0; wb_wen_i = 1'b1; wb_waddr_i = 5'd7; wb_wdata_i = 64'hDEAD;
        step(); wb_wen_i = 1'b0; ex_ready_i = 1'b1;
        @(negedge clk); check("t4b_rs1", ex_rs1_val_o, 64'hDEAD);
        step(); ex_ready_i = 1'b0;

        // Stall in FULL with a snooped write, then back-to-back accept.
        dec_valid_i = 1'b1; dec_rs1_i = 5'd9; dec_rs2_i = 5'd9; dec_need_rs2_i = 1'b0;
        step(); dec_valid_i = 1'b0;
        step();
        @(negedge clk); check("t5_c1_rs1", ex_rs1_val_o, 64'h1234);
        step(); wb_wen_i = 1'b1; wb_waddr_i = 5'd9; wb_wdata_i = 64'h55;
        @(negedge clk); check("t5_c2_rs1", ex_rs1_val_o, 64'h1234);
        step(); wb_wen_i = 1'b0;
        @(negedge clk);
        check("t5_c3_rs1", ex_rs1_val_o, 64'h55);
        check("t5_c3_rs2", ex_rs2_val_o, 64'd0);
        check("t5_c3_valid", {63'd0, ex_valid_o}, 64'd1);
        step(); ex_ready_i = 1'b1; dec_valid_i = 1'b1; dec_rs1_i = 5'd2; dec_need_rs2_i = 1'b0;
        @(negedge clk);
        check("t6_valid", {63'd0, ex_valid_o}, 64'd1);
        check("t6_dec_ready", {63'd0, dec_ready_o}, 64'd1);
        check("t6_raddr", {59'd0, rf_raddr_o}, 64'd2);
        step(); dec_valid_i = 1'b0; ex_ready_i = 1'b0;
        @(negedge clk); check("t6_gap", {63'd0, ex_valid_o}, 64'd0);
        step(); ex_ready_i = 1'b1;
        @(negedge clk);
        check("t6_valid2", {63'd0, ex_valid_o}, 64'd1);
        check("t6_rs1", ex_rs1_val_o, 64'h42);
        step(); ex_ready_i = 1'b0;

        // Reset in the middle of RD2 drops the instruction.
        dec_valid_i = 1'b1; dec_rs1_i = 5'd3; dec_rs2_i = 5'd4; dec_need_rs2_i = 1'b1;
        step(); dec_valid_i = 1'b0;
        step(); reset_i = 1'b1;
        step(); reset_i = 1'b0; ex_ready_i = 1'b1;
        @(negedge clk);
        check("t1_valid", {63'd0, ex_valid_o}, 64'd0);
        check("t1_dec_ready", {63'd0, dec_ready_o}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk); check("t1_no_ex", {63'd0, ex_valid_o}, 64'd0);
        end

        // Randomised traffic with small index ranges to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step();
            reset_i        = ($urandom_range(0, 199) == 0);
            dec_valid_i    = $urandom_range(0, 1) == 1;
            dec_rs1_i      = 5'($urandom_range(0, 7));
            dec_rs2_i      = 5'($urandom_range(0, 7));
            dec_need_rs2_i = $urandom_range(0, 1) == 1;
            dec_payload_i  = $urandom;
            ex_ready_i     = $urandom_range(0, 9) < 6;
            wb_wen_i       = $urandom_range(0, 9) < 4;
            wb_waddr_i     = 5'($urandom_range(0, 7));
            wb_wdata_i     = {$urandom, $urandom};
        end
        step();
        reset_i = 1'b0; dec_valid_i = 1'b0; wb_wen_i = 1'b0; ex_ready_i = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
